key_input_control: RTL and testbench
====================================

Name: key_input_control

Overview:
- Avalon-MM slave peripheral for the board pushbuttons; it carries data from the board to the CPU, the opposite direction of the HEX display writer.
- Synchronizes and debounces NUM_KEYS active-low keys and latches press events in an edge-capture register.
- Raises a maskable interrupt on latched presses.
- Exposes debounced state, IRQ mask, edge capture and raw synchronized level as 8-bit registers read with latency 1.

Parameters:
- NUM_KEYS, 4, number of keys; legal range 1..8.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced level changes (10 ms at 50 MHz); must be at least 2.
- CNT_WIDTH, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- iClk  in  1  system clock.
- iReset_n  in  1  asynchronous active-low reset.
- iChip_select_n  in  1  Avalon chip select, active low.
- iRead_n  in  1  Avalon read strobe, active low.
- iWrite_n  in  1  Avalon write strobe, active low.
- iAddress  in  2  register select.
- iWritedata  in  8  write data; only bits [NUM_KEYS-1:0] are used.
- oReaddata  out  8  registered read data.
- oIrq  out  1  interrupt request, active high.
- iKey  in  NUM_KEYS  raw pushbuttons, asynchronous, 0 = pressed.

Behaviour:
- Clock and reset: one clock, iClk. iReset_n is asynchronous and active-low.
- Reset values:
  - sync stages all 1 (released);
  - debounced state 0;
  - counters 0;
  - mask 0;
  - edge capture 0;
  - oReaddata 0x00;
  - oIrq 0.
- Synchronizer: two flops per key on inverted iKey, so 1 = pressed inside the block. Call the stage-2 output sync[k].
- Debounce, per key k, evaluated each cycle:
  - sync[k] == deb[k]: counter clears to 0.
  - sync[k] != deb[k] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync[k] != deb[k] and counter == DEBOUNCE_CYCLES-1: deb[k] <= sync[k] and counter clears.
- Debounce consequences:
  - deb changes on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  - Any single-cycle agreement restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Latency: from iKey falling (sampled) to deb rising is 2 + DEBOUNCE_CYCLES cycles.
- Edge capture:
  - edge[k] sets on the cycle deb[k] goes 0->1 (press only; release does not set it).
  - edge[k] stays set until cleared by software.
- Register map:
  - 0 DATA, RO: deb.
  - 1 IRQMASK, RW: mask.
  - 2 EDGE, R/W1C: edge.
  - 3 RAW, RO: sync.
  - Bits [7:NUM_KEYS] always read 0.
- Write: on a clock edge with ~iChip_select_n & ~iWrite_n:
  - addr 1: mask <= iWritedata[NUM_KEYS-1:0].
  - addr 2: edge[k] cleared where iWritedata[k] = 1.
  - addr 0 and addr 3: write ignored.
- Write-clear vs new press: if a write-1-clear and a new press edge hit the same bit in the same cycle, set wins and the bit stays 1.
- Read:
  - On a clock edge with ~iChip_select_n & ~iRead_n, oReaddata <= selected register, valid the cycle after the strobe (read latency 1).
  - On any other edge oReaddata <= 0x00.
  - Back-to-back reads are supported, one result per cycle.
  - If read and write are both asserted in one cycle, the write takes effect and the read returns the pre-write value.
- Interrupt: oIrq = |(edge & mask), driven from registers only.
  - oIrq rises the cycle after edge or mask updates.
  - oIrq falls the cycle after the clearing write.
- Reset mid-debounce: all state returns to reset values at once; a key still held after reset must re-qualify through the full debounce, then sets edge.
- Keys never pressed: state, edge and IRQ stay 0 indefinitely.

Test Plan:
- Setup: DEBOUNCE_CYCLES=4, NUM_KEYS=4.
- Reset check: pulse iReset_n low mid-run, then read addresses 0..3 -> each returns 0x00 one cycle after its strobe; oIrq=0.
- Debounce and edge: hold iKey=4'b1110 steady -> DATA reads 0x01 after 2+4 cycles, not earlier. EDGE reads 0x01. Release -> DATA returns to 0x00 after 6 cycles and EDGE stays 0x01.
- Glitch rejection: iKey[1] low for 3 cycles, high 1 cycle, low 3 cycles -> DATA stays 0x00 and EDGE stays 0x00. Holding it low for 4 more cycles then gives DATA=0x02.
- IRQ masking:
  - edge=0x05 with mask=0 -> oIrq=0.
  - Write IRQMASK=0x04 -> oIrq=1 the next cycle.
  - Write EDGE=0x04 -> oIrq=0 the next cycle, and EDGE reads 0x01.
- Clear/set collision: W1C write of 0x08 on the exact cycle deb[3] rises -> EDGE bit 3 reads 1.
- Read protocol: back-to-back reads of addr 3 then addr 1 with key0 pressed and mask=0x0F -> 0x01 then 0x0F on consecutive cycles; oReaddata=0x00 on the following idle cycle. A write to addr 0 leaves DATA unchanged.

Source files
------------

// File: rtl/key_input_control.sv
// key_input_control: Avalon-MM slave for the board pushbuttons.
//
// Each active-low key is synchronized through two flops and then debounced.
// A debounced level change is accepted only after DEBOUNCE_CYCLES
// consecutive cycles of disagreement. A debounced press (0->1) latches a bit
// in the edge-capture register. Captured edges gated by the IRQ mask drive
// the interrupt.
//
// Ports:
//   iClk            system clock
//   iReset_n        asynchronous active-low reset
//   iChip_select_n  Avalon chip select, active low
//   iRead_n         Avalon read strobe, active low
//   iWrite_n        Avalon write strobe, active low
//   iAddress        register select: 0 DATA, 1 IRQMASK, 2 EDGE (W1C), 3 RAW
//   iWritedata      write data, bits [NUM_KEYS-1:0] used
//   oReaddata       registered read data, latency 1, 0x00 when not reading
//   oIrq            interrupt request, |(edge & mask)
//   iKey            raw pushbuttons, asynchronous, 0 = pressed
module key_input_control #(
   parameter int unsigned NUM_KEYS        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_WIDTH       = 20
) (
   input  logic                iClk,
   input  logic                iReset_n,
   input  logic                iChip_select_n,
   input  logic                iRead_n,
   input  logic                iWrite_n,
   input  logic [1:0]          iAddress,
   input  logic [7:0]          iWritedata,
   output logic [7:0]          oReaddata,
   output logic                oIrq,
   input  logic [NUM_KEYS-1:0] iKey
);

   localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   // Synchronizer flops hold the raw (active-low) level so that their reset
   // value of all ones means "released"; inversion happens after stage 2.
   logic [NUM_KEYS-1:0]  keyMetaQ;
   logic [NUM_KEYS-1:0]  keyStableQ;
   logic [NUM_KEYS-1:0]  sync;

   logic [NUM_KEYS-1:0]  debQ, debD;
   logic [CNT_WIDTH-1:0] cntQ [NUM_KEYS];
   logic [CNT_WIDTH-1:0] cntD [NUM_KEYS];
   logic [NUM_KEYS-1:0]  pressEvt;

   logic [NUM_KEYS-1:0]  maskQ, maskD;
   logic [NUM_KEYS-1:0]  edgeQ, edgeD;
   logic [NUM_KEYS-1:0]  edgeClr;
   logic [NUM_KEYS-1:0]  regSel;
   logic [7:0]           readdataQ, readdataD;

   logic                 wrEn;
   logic                 rdEn;
   logic                 unusedWritedata;

   assign sync = ~keyStableQ;
   assign wrEn = ~iChip_select_n & ~iWrite_n;
   assign rdEn = ~iChip_select_n & ~iRead_n;

   // Upper write-data bits are meaningless when NUM_KEYS < 8.
   assign unusedWritedata = ^iWritedata;

   // Debounce: count consecutive mismatches, accept the new level on the
   // DEBOUNCE_CYCLES-th one; any agreeing cycle restarts the count.
   always_comb begin
      debD     = debQ;
      pressEvt = '0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
         cntD[k] = '0;
         if (sync[k] != debQ[k]) begin
            if (cntQ[k] == CntMax) begin
               debD[k]     = sync[k];
               pressEvt[k] = sync[k];
            end else begin
               cntD[k] = cntQ[k] + 1'b1;
            end
         end
      end
   end

   // Register writes; a press edge overrides a same-cycle write-1-clear.
   always_comb begin
      maskD   = maskQ;
      edgeClr = '0;
      if (wrEn) begin
         case (iAddress)
            2'd1:    maskD   = iWritedata[NUM_KEYS-1:0];
            2'd2:    edgeClr = iWritedata[NUM_KEYS-1:0];
            default: ;
         endcase
      end
      edgeD = (edgeQ & ~edgeClr) | pressEvt;
   end

   // Read mux samples pre-write register values.
   always_comb begin
      case (iAddress)
         2'd0:    regSel = debQ;
         2'd1:    regSel = maskQ;
         2'd2:    regSel = edgeQ;
         default: regSel = sync;
      endcase
      readdataD = rdEn ? 8'(regSel) : 8'h00;
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         keyMetaQ   <= '1;
         keyStableQ <= '1;
         debQ       <= '0;
         maskQ      <= '0;
         edgeQ      <= '0;
         readdataQ  <= 8'h00;
         for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            cntQ[k] <= '0;
         end
      end else begin
         keyMetaQ   <= iKey;
         keyStableQ <= keyMetaQ;
         debQ       <= debD;
         maskQ      <= maskD;
         edgeQ      <= edgeD;
         readdataQ  <= readdataD;
         for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            cntQ[k] <= cntD[k];
         end
      end
   end

   assign oReaddata = readdataQ;
   assign oIrq      = |(edgeQ & maskQ);

endmodule

// File: tb/tb_key_input_control.sv
module tb_key_input_control;

   localparam int unsigned NumKeys = 4;
   localparam int unsigned DebCyc  = 4;

   logic               iClk = 1'b0;
   logic               iReset_n;
   logic               iChip_select_n;
   logic               iRead_n;
   logic               iWrite_n;
   logic [1:0]         iAddress;
   logic [7:0]         iWritedata;
   logic [7:0]         oReaddata;
   logic               oIrq;
   logic [NumKeys-1:0] iKey;

   int nVec = 0;
   int nErr = 0;

   always #5 iClk = ~iClk;

   key_input_control #(
      .NUM_KEYS        (NumKeys),
      .DEBOUNCE_CYCLES (DebCyc),
      .CNT_WIDTH       (3)
   ) dut (
      .iClk           (iClk),
      .iReset_n       (iReset_n),
      .iChip_select_n (iChip_select_n),
      .iRead_n        (iRead_n),
      .iWrite_n       (iWrite_n),
      .iAddress       (iAddress),
      .iWritedata     (iWritedata),
      .oReaddata      (oReaddata),
      .oIrq           (oIrq),
      .iKey           (iKey)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   task automatic busRead(input logic [1:0] a, output logic [7:0] d);
      iChip_select_n = 1'b0;
      iRead_n        = 1'b0;
      iAddress       = a;
      @(posedge iClk);
      #1;
      iChip_select_n = 1'b1;
      iRead_n        = 1'b1;
      d              = oReaddata;
   endtask

   task automatic busWrite(input logic [1:0] a, input logic [7:0] wd);
      iChip_select_n = 1'b0;
      iWrite_n       = 1'b0;
      iAddress       = a;
      iWritedata     = wd;
      @(posedge iClk);
      #1;
      iChip_select_n = 1'b1;
      iWrite_n       = 1'b1;
   endtask

   task automatic test_debounce_edge();
      logic [7:0] arr [8];
      logic [7:0] d;
      iKey = 4'b1110;
      for (int i = 0; i < 8; i++) begin
         busRead(2'd0, d);
         arr[i] = d;
      end
      nVec++;
      if (arr[5] !== 8'h00) begin
         nErr++;
         $display("FAIL press_early: DATA got %h want 00", arr[5]);
      end
      nVec++;
      if (arr[6] !== 8'h01) begin
         nErr++;
         $display("FAIL press_on_time: DATA got %h want 01", arr[6]);
      end
      busRead(2'd2, d);
      nVec++;
      if (d !== 8'h01) begin
         nErr++;
         $display("FAIL press_edge: EDGE got %h want 01", d);
      end
      iKey = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         busRead(2'd0, d);
         arr[i] = d;
      end
      nVec++;
      if (arr[5] !== 8'h01) begin
         nErr++;
         $display("FAIL release_early: DATA got %h want 01", arr[5]);
      end
      nVec++;
      if (arr[6] !== 8'h00) begin
         nErr++;
         $display("FAIL release_on_time: DATA got %h want 00", arr[6]);
      end
      busRead(2'd2, d);
      nVec++;
      if (d !== 8'h01) begin
         nErr++;
         $display("FAIL release_edge: EDGE got %h want 01", d);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] d;
      busWrite(2'd2, 8'h0F);
      iKey = 4'b1101;
      tick(3);
      iKey = 4'b1111;
      tick(1);
      iKey = 4'b1101;
      tick(3);
      busRead(2'd0, d);
      nVec++;
      if (d !== 8'h00) begin
         nErr++;
         $display("FAIL glitch_data: DATA got %h want 00", d);
      end
      busRead(2'd2, d);
      nVec++;
      if (d !== 8'h00) begin
         nErr++;
         $display("FAIL glitch_edge: EDGE got %h want 00", d);
      end
      tick(4);
      busRead(2'd0, d);
      nVec++;
      if (d !== 8'h02) begin
         nErr++;
         $display("FAIL glitch_hold: DATA got %h want 02", d);
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      busWrite(2'd1, 8'h0F);
      nVec++;
      if (oIrq !== 1'b1) begin
         nErr++;
         $display("FAIL pre_reset_irq: oIrq got %b want 1", oIrq);
      end
      iKey     = 4'b1111;
      iReset_n = 1'b0;
      #1;
      nVec++;
      if (oIrq !== 1'b0) begin
         nErr++;
         $display("FAIL reset_irq: oIrq got %b want 0", oIrq);
      end
      tick(2);
      iReset_n = 1'b1;
      tick(1);
      for (int a = 0; a < 4; a++) begin
         busRead(2'(a), d);
         nVec++;
         if (d !== 8'h00) begin
            nErr++;
            $display("FAIL reset_reg%0d: read got %h want 00", a, d);
         end
      end
   endtask

   task automatic test_irq_mask();
      logic [7:0] d;
      iKey = 4'b1010;
      tick(8);
      nVec++;
      if (oIrq !== 1'b0) begin
         nErr++;
         $display("FAIL irq_masked: oIrq got %b want 0", oIrq);
      end
      busRead(2'd2, d);
      nVec++;
      if (d !== 8'h05) begin
         nErr++;
         $display("FAIL irq_edge: EDGE got %h want 05", d);
      end
      busWrite(2'd1, 8'h04);
      nVec++;
      if (oIrq !== 1'b1) begin
         nErr++;
         $display("FAIL irq_unmask: oIrq got %b want 1", oIrq);
      end
      busWrite(2'd2, 8'h04);
      nVec++;
      if (oIrq !== 1'b0) begin
         nErr++;
         $display("FAIL irq_clear: oIrq got %b want 0", oIrq);
      end
      busRead(2'd2, d);
      nVec++;
      if (d !== 8'h01) begin
         nErr++;
         $display("FAIL irq_edge_after_clr: EDGE got %h want 01", d);
      end
   endtask

   task automatic test_collision();
      logic [7:0] d;
      iKey = 4'b0010;
      tick(5);
      // This write lands on the same edge at which deb[3] rises.
      busWrite(2'd2, 8'h08);
      busRead(2'd2, d);
      nVec++;
      if (d !== 8'h09) begin
         nErr++;
         $display("FAIL collision_edge: EDGE got %h want 09", d);
      end
      busRead(2'd0, d);
      nVec++;
      if (d !== 8'h0D) begin
         nErr++;
         $display("FAIL collision_data: DATA got %h want 0d", d);
      end
      busWrite(2'd2, 8'h08);
      busRead(2'd2, d);
      nVec++;
      if (d !== 8'h01) begin
         nErr++;
         $display("FAIL w1c_plain: EDGE got %h want 01", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d1;
      logic [7:0] d2;
      logic [7:0] d3;
      iKey = 4'b1110;
      tick(8);
      busWrite(2'd1, 8'h0F);
      iChip_select_n = 1'b0;
      iRead_n        = 1'b0;
      iAddress       = 2'd3;
      @(posedge iClk);
      #1;
      d1       = oReaddata;
      iAddress = 2'd1;
      @(posedge iClk);
      #1;
      d2             = oReaddata;
      iChip_select_n = 1'b1;
      iRead_n        = 1'b1;
      @(posedge iClk);
      #1;
      d3 = oReaddata;
      nVec++;
      if (d1 !== 8'h01) begin
         nErr++;
         $display("FAIL b2b_raw: got %h want 01", d1);
      end
      nVec++;
      if (d2 !== 8'h0F) begin
         nErr++;
         $display("FAIL b2b_mask: got %h want 0f", d2);
      end
      nVec++;
      if (d3 !== 8'h00) begin
         nErr++;
         $display("FAIL b2b_idle: got %h want 00", d3);
      end
      busWrite(2'd0, 8'hFF);
      busRead(2'd0, d1);
      nVec++;
      if (d1 !== 8'h01) begin
         nErr++;
         $display("FAIL ro_data_write: DATA got %h want 01", d1);
      end
      // Simultaneous read and write: read returns the old mask.
      iChip_select_n = 1'b0;
      iRead_n        = 1'b0;
      iWrite_n       = 1'b0;
      iAddress       = 2'd1;
      iWritedata     = 8'h03;
      @(posedge iClk);
      #1;
      d1             = oReaddata;
      iChip_select_n = 1'b1;
      iRead_n        = 1'b1;
      iWrite_n       = 1'b1;
      nVec++;
      if (d1 !== 8'h0F) begin
         nErr++;
         $display("FAIL rw_same_cycle: got %h want 0f", d1);
      end
      busRead(2'd1, d2);
      nVec++;
      if (d2 !== 8'h03) begin
         nErr++;
         $display("FAIL rw_mask_after: got %h want 03", d2);
      end
   endtask

   initial begin
      iReset_n       = 1'b0;
      iChip_select_n = 1'b1;
      iRead_n        = 1'b1;
      iWrite_n       = 1'b1;
      iAddress       = 2'd0;
      iWritedata     = 8'h00;
      iKey           = 4'b1111;
      tick(3);
      iReset_n = 1'b1;
      tick(4);
      test_debounce_edge();
      test_glitch();
      test_reset();
      test_irq_mask();
      test_collision();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
